// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle controller: FSM states, opcode/funct3
// fields, ALU operation codes and the instruction-class decode helper.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_IALU    = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_ILLEGAL = 3'd5
    } iclass_e;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b1101;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1111;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1010;

    // Only BEQ is implemented among the branches; other funct3 values are illegal.
    function automatic iclass_e classify(input logic [6:0] opcode, input logic [2:0] funct3);
        iclass_e cls;
        case (opcode)
            OP_RTYPE:  cls = CLS_RTYPE;
            OP_IALU:   cls = CLS_IALU;
            OP_LOAD:   cls = CLS_LOAD;
            OP_STORE:  cls = CLS_STORE;
            OP_BRANCH: cls = (funct3 == F3_BEQ) ? CLS_BRANCH : CLS_ILLEGAL;
            default:   cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction/flag inputs to the controller and
// every control strobe it drives back; master = controller, slave = datapath.
interface multicycle_ctrl_if #(
    parameter int RET_W = 32
);
    logic [31:0]      instr;
    logic             Zero;
    logic             mem_ready;
    logic             PCSrc;
    logic             ALUSrc;
    logic             RegWrite;
    logic             MemToReg;
    logic [3:0]       ALUCtrl;
    logic             loadPC;
    logic             MemRead;
    logic             MemWrite;
    logic             instr_done;
    logic [RET_W-1:0] retired;
    logic             halted;

    modport master (
        input  instr, Zero, mem_ready,
        output PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC,
               MemRead, MemWrite, instr_done, retired, halted
    );

    modport slave (
        output instr, Zero, mem_ready,
        input  PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC,
               MemRead, MemWrite, instr_done, retired, halted
    );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU operation/operand-select decode from opcode, funct3 and instr[30];
// zero latency, no state.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       bit30_i,
    output logic [3:0] alu_ctrl_o,
    output logic       alu_src_o
);

    logic [3:0] arith_code;

    // Shared R/I funct3 table; the subtract override applies to R-type only.
    always_comb begin
        arith_code = ALU_ADD;
        case (funct3_i)
            F3_ADD:  arith_code = ALU_ADD;
            F3_SLL:  arith_code = ALU_SLL;
            F3_SLT:  arith_code = ALU_SLT;
            F3_SLTU: arith_code = ALU_SLTU;
            F3_XOR:  arith_code = ALU_XOR;
            F3_SR:   arith_code = bit30_i ? ALU_SRA : ALU_SRL;
            F3_OR:   arith_code = ALU_OR;
            F3_AND:  arith_code = ALU_AND;
            default: arith_code = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        alu_src_o  = 1'b0;
        case (classify(opcode_i, funct3_i))
            CLS_RTYPE: begin
                alu_ctrl_o = (funct3_i == F3_ADD && bit30_i) ? ALU_SUB : arith_code;
                alu_src_o  = 1'b0;
            end
            CLS_IALU: begin
                alu_ctrl_o = arith_code;
                alu_src_o  = 1'b1;
            end
            CLS_LOAD, CLS_STORE: begin
                alu_ctrl_o = ALU_ADD;
                alu_src_o  = 1'b1;
            end
            CLS_BRANCH: begin
                alu_ctrl_o = ALU_SUB;
                alu_src_o  = 1'b0;
            end
            default: begin
                alu_ctrl_o = ALU_ADD;
                alu_src_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// RV32I multicycle controller: IF/ID/EX/(MEM)/WB sequencing, MEM stalls on mem_ready.
// ILLEGAL_TRAP_EN: illegal instructions halt (sticky until rst) instead of retiring as NOPs.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int RET_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_ctrl_if.master     bus
);

    state_e           state_q, state_d;
    logic [RET_W-1:0] retired_q, retired_d;
    iclass_e          cls;
    logic             is_load, is_store, is_branch, writes_rd;
    logic             reg_write, load_pc, mem_read, mem_write, pc_src, done;
    logic             unused_instr_bits;

    assign cls       = classify(bus.instr[6:0], bus.instr[14:12]);
    assign is_load   = (cls == CLS_LOAD);
    assign is_store  = (cls == CLS_STORE);
    assign is_branch = (cls == CLS_BRANCH);
    assign writes_rd = (cls == CLS_RTYPE) || (cls == CLS_IALU) || is_load;
    assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

    alu_decoder u_alu_decoder (
        .opcode_i   (bus.instr[6:0]),
        .funct3_i   (bus.instr[14:12]),
        .bit30_i    (bus.instr[30]),
        .alu_ctrl_o (bus.ALUCtrl),
        .alu_src_o  (bus.ALUSrc)
    );

`ifdef ILLEGAL_TRAP_EN
    logic halted_q, halted_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IF;
            retired_q <= '0;
`ifdef ILLEGAL_TRAP_EN
            halted_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
`ifdef ILLEGAL_TRAP_EN
            halted_q  <= halted_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        retired_d = retired_q;
        reg_write = 1'b0;
        load_pc   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        pc_src    = 1'b0;
        done      = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        halted_d  = halted_q;
`endif
        case (state_q)
            ST_IF: state_d = ST_ID;
            ST_ID: state_d = ST_EX;
            ST_EX: begin
                if (is_load || is_store) begin
                    state_d = ST_MEM;
`ifdef ILLEGAL_TRAP_EN
                end else if (cls == CLS_ILLEGAL) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
`endif
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                mem_read  = is_load;
                mem_write = is_store;
                if (bus.mem_ready) begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                // Illegal instructions reach here only as NOPs: PC advances, no write.
                reg_write = writes_rd;
                load_pc   = 1'b1;
                mem_read  = is_load;
                pc_src    = is_branch && bus.Zero;
                done      = 1'b1;
                retired_d = retired_q + RET_W'(1);
                state_d   = ST_IF;
            end
`ifdef ILLEGAL_TRAP_EN
            ST_HALT: state_d = ST_HALT;
`endif
            default: state_d = ST_IF;
        endcase
    end

    // Reset gates every enable in the same cycle so an aborted instruction has no effect.
    assign bus.RegWrite   = reg_write & ~rst;
    assign bus.loadPC     = load_pc   & ~rst;
    assign bus.MemRead    = mem_read  & ~rst;
    assign bus.MemWrite   = mem_write & ~rst;
    assign bus.PCSrc      = pc_src    & ~rst;
    assign bus.instr_done = done      & ~rst;
    assign bus.MemToReg   = is_load;
    assign bus.retired    = retired_q;

`ifdef ILLEGAL_TRAP_EN
    assign bus.halted = halted_q;
`else
    assign bus.halted = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, reset/trap sequences and random
// instructions checked against a phase-sequence model built from the ISA rules.
module tb_multicycle_ctrl;

    localparam int RW = 4;
    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_ILL = 5;
    localparam int PH_IF = 0, PH_ID = 1, PH_EX = 2, PH_MEM = 3, PH_WB = 4, PH_HALT = 5;
    localparam logic [12:0] MASK_ALL  = 13'b1_1111_1111_1111;
    localparam logic [12:0] MASK_NOALU = 13'b1_0110_0001_1111;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    int   model_retired = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.RET_W(RW)) bus ();
    multicycle_ctrl #(.RET_W(RW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic        z;
        int          w;
        logic [3:0]  alu;
        logic        src;
    } vec_t;

    function automatic int kind_of(input logic [31:0] i);
        case (i[6:0])
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0000011: return K_LW;
            7'b0100011: return K_SW;
            7'b1100011: return (i[14:12] == 3'b000) ? K_BEQ : K_ILL;
            default:    return K_ILL;
        endcase
    endfunction

    // {ALUSrc, ALUCtrl} from the instruction-set description.
    function automatic logic [4:0] ref_alu(input logic [31:0] i);
        int         k;
        logic [3:0] code;
        k = kind_of(i);
        case (i[14:12])
            3'd0: code = 4'b0010;
            3'd1: code = 4'b1001;
            3'd2: code = 4'b0111;
            3'd3: code = 4'b1111;
            3'd4: code = 4'b1101;
            3'd5: code = i[30] ? 4'b1010 : 4'b1000;
            3'd6: code = 4'b0001;
            default: code = 4'b0000;
        endcase
        if (k == K_R && i[14:12] == 3'd0 && i[30]) code = 4'b0110;
        if (k == K_R)                 return {1'b0, code};
        if (k == K_I)                 return {1'b1, code};
        if (k == K_LW || k == K_SW)   return {1'b1, 4'b0010};
        if (k == K_BEQ)               return {1'b0, 4'b0110};
        return {1'b0, 4'b0010};
    endfunction

    function automatic logic [31:0] rand_instr(input int k);
        logic [31:0] r;
        r = $urandom;
        case (k)
            K_R:   r[6:0] = 7'b0110011;
            K_I:   r[6:0] = 7'b0010011;
            K_LW:  r[6:0] = 7'b0000011;
            K_SW:  r[6:0] = 7'b0100011;
            K_BEQ: begin r[6:0] = 7'b1100011; r[14:12] = 3'b000; end
            default: begin
                case ($urandom_range(0, 3))
                    0: begin r[6:0] = 7'b1100011; r[14:12] = 3'($urandom_range(1, 7)); end
                    1: r[6:0] = 7'b1111111;
                    2: r[6:0] = 7'b0110111;
                    default: r[6:0] = 7'b1101111;
                endcase
            end
        endcase
        return r;
    endfunction

    // Packed: {PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC, MemRead, MemWrite, instr_done, halted}
    function automatic logic [12:0] exp_out(input int ph, input int k, input logic z,
                                            input logic [3:0] alu, input logic src, input logic in_rst);
        logic wb, mem, rw, lp, mr, mw, pc, dn, hl;
        wb = (ph == PH_WB);
        mem = (ph == PH_MEM);
        rw = wb && (k == K_R || k == K_I || k == K_LW);
        lp = wb;
        mr = (k == K_LW) && (mem || wb);
        mw = (k == K_SW) && mem;
        pc = wb && (k == K_BEQ) && z;
        dn = wb;
        hl = (ph == PH_HALT);
        if (in_rst) {rw, lp, mr, mw, pc, dn} = 6'b0;
        return {pc, src, rw, (k == K_LW), alu, lp, mr, mw, dn, hl};
    endfunction

    task automatic check(input string name, input logic [12:0] exp, input logic [12:0] mask);
        logic [12:0]   act;
        logic [RW-1:0] er;
        act = {bus.PCSrc, bus.ALUSrc, bus.RegWrite, bus.MemToReg, bus.ALUCtrl,
               bus.loadPC, bus.MemRead, bus.MemWrite, bus.instr_done, bus.halted};
        er = RW'(model_retired % (1 << RW));
        vectors++;
        if (((act & mask) !== (exp & mask)) || (bus.retired !== er)) begin
            miscompares++;
            $display("FAIL %s @%0t: got ctl=%b retired=%0d, expected ctl=%b retired=%0d (mask %b)",
                     name, $time, act, bus.retired, exp, er, mask);
        end
    endtask

    // Runs one instruction starting in IF; abort_at >= 0 asserts rst on that cycle.
    task automatic run_instr(input string name, input logic [31:0] ins, input logic z, input int w,
                             input logic [3:0] alu, input logic src, input int abort_at);
        int          k;
        int          ph[$];
        int          memcnt;
        logic [12:0] mask;
        k = kind_of(ins);
        ph = '{PH_IF, PH_ID, PH_EX};
        if (k == K_LW || k == K_SW) for (int i = 0; i <= w; i++) ph.push_back(PH_MEM);
        ph.push_back(PH_WB);
        mask = (k == K_ILL) ? MASK_NOALU : MASK_ALL;
        memcnt = 0;
        bus.instr = ins;
        bus.Zero = z;
        for (int c = 0; c < ph.size(); c++) begin
            if (ph[c] == PH_MEM) begin
                bus.mem_ready = (memcnt == w);
                memcnt++;
            end else begin
                bus.mem_ready = 1'($urandom_range(0, 1));
            end
            if (c == abort_at) begin
                rst = 1'b1;
                bus.mem_ready = 1'b0;
                @(negedge clk);
                check({name, "_rst"}, exp_out(ph[c], k, z, alu, src, 1'b1), mask);
                @(posedge clk); #1;
                rst = 1'b0;
                model_retired = 0;
                return;
            end
            @(negedge clk);
            check(name, exp_out(ph[c], k, z, alu, src, 1'b0), mask);
            @(posedge clk); #1;
            if (ph[c] == PH_WB) model_retired++;
        end
    endtask

    initial begin
        vec_t        tbl[$];
        logic [31:0] ins;
        logic [4:0]  ra;
        int          k;

        tbl.push_back('{"add",    32'h002081B3, 1'b0, 0, 4'b0010, 1'b0});
        tbl.push_back('{"sub",    32'h402081B3, 1'b0, 0, 4'b0110, 1'b0});
        tbl.push_back('{"srl",    32'h0020D1B3, 1'b0, 0, 4'b1000, 1'b0});
        tbl.push_back('{"sra",    32'h4020D1B3, 1'b0, 0, 4'b1010, 1'b0});
        tbl.push_back('{"sltu",   32'h0020B1B3, 1'b0, 0, 4'b1111, 1'b0});
        tbl.push_back('{"addi30", 32'h40008093, 1'b0, 0, 4'b0010, 1'b1});
        tbl.push_back('{"srai",   32'h4010D093, 1'b0, 0, 4'b1010, 1'b1});
        tbl.push_back('{"xori",   32'h0000C093, 1'b0, 0, 4'b1101, 1'b1});
        tbl.push_back('{"lw_w3",  32'h00402283, 1'b0, 3, 4'b0010, 1'b1});
        tbl.push_back('{"lw_w0",  32'h00402283, 1'b1, 0, 4'b0010, 1'b1});
        tbl.push_back('{"sw",     32'h00502423, 1'b0, 0, 4'b0010, 1'b1});
        tbl.push_back('{"beq_z1", 32'h00000463, 1'b1, 0, 4'b0110, 1'b0});
        tbl.push_back('{"beq_z0", 32'h00000463, 1'b0, 0, 4'b0110, 1'b0});
`ifndef ILLEGAL_TRAP_EN
        tbl.push_back('{"ill_nop", 32'hFFFFFFFF, 1'b1, 0, 4'b0010, 1'b0});
        tbl.push_back('{"bne_nop", 32'h00001463, 1'b1, 0, 4'b0010, 1'b0});
`endif

        rst = 1'b1;
        bus.instr = 32'h002081B3;
        bus.Zero = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset", exp_out(PH_IF, K_R, 1'b0, 4'b0010, 1'b0, 1'b1), MASK_ALL);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (tbl[i])
            run_instr(tbl[i].name, tbl[i].ins, tbl[i].z, tbl[i].w, tbl[i].alu, tbl[i].src, -1);

        // Reset during the second MEM wait cycle of a load, then a clean load.
        run_instr("lw_abort", 32'h00402283, 1'b0, 3, 4'b0010, 1'b1, 4);
        run_instr("lw_after", 32'h00402283, 1'b0, 1, 4'b0010, 1'b1, -1);

        for (int n = 0; n < 40; n++) begin
`ifdef ILLEGAL_TRAP_EN
            k = $urandom_range(K_R, K_BEQ);
`else
            k = $urandom_range(K_R, K_ILL);
`endif
            ins = rand_instr(k);
            ra = ref_alu(ins);
            run_instr("rand", ins, 1'($urandom_range(0, 1)), $urandom_range(0, 3), ra[3:0], ra[4], -1);
        end

`ifdef ILLEGAL_TRAP_EN
        bus.instr = 32'hFFFFFFFF;
        bus.Zero = 1'b1;
        for (int c = 0; c < 13; c++) begin
            bus.mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("trap", exp_out((c < 3) ? c : PH_HALT, K_ILL, 1'b1, 4'b0010, 1'b0, 1'b0), MASK_NOALU);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_retired = 0;
        run_instr("post_trap", 32'h002081B3, 1'b0, 0, 4'b0010, 1'b0, -1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
